// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce
// Purpose  : Conditions the raw slide-switch inputs for the switch-to-LED
//            logic. Each switch is synchronised to clk through a two-flop
//            chain and then filtered. A new level is accepted only after it
//            has been held for STABLE_CYCLES consecutive cycles. Any shorter
//            excursion is discarded in full.
// Ports    : clk      - system clock (100 MHz on board)
//            rst      - asynchronous, active-high reset
//            sw_pin   - raw switch levels, asynchronous to clk
//            sw_db    - debounced switch levels (registered)
//            sw_chg   - one-cycle pulse per bit when the sw_db bit toggles
//            any_chg  - OR of sw_chg, in the same cycle (registered)
//            sw_rise  - sw_chg bits whose new level is 1
//                       (present only with SW_DEBOUNCE_EDGE_DIR_EN)
//            sw_fall  - sw_chg bits whose new level is 0
//                       (present only with SW_DEBOUNCE_EDGE_DIR_EN)
// Options  : define SW_DEBOUNCE_EDGE_DIR_EN to add sw_rise / sw_fall
// Revision : 1.0 - initial release
// ============================================================================
module sw_debounce #(
    parameter int unsigned N_SW          = 8,
    parameter int unsigned STABLE_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_pin,
    output logic [N_SW-1:0] sw_db,
    output logic [N_SW-1:0] sw_chg,
`ifdef SW_DEBOUNCE_EDGE_DIR_EN
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
`endif
    output logic            any_chg
);

    // The counter only has to reach STABLE_CYCLES-1 before it clears, so
    // clog2(STABLE_CYCLES) bits are sufficient and the counter never wraps.
    localparam int unsigned     CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N_SW-1:0]  r_s1;
    logic [N_SW-1:0]  r_s2;
    logic [CNT_W-1:0] r_cnt     [N_SW];
    logic [CNT_W-1:0] w_cnt_nxt [N_SW];
    logic [N_SW-1:0]  w_db_nxt;
    logic [N_SW-1:0]  w_chg_nxt;

    // Per-channel filter. The channel is PENDING whenever the synchronised
    // level differs from the accepted level. The equality test is evaluated
    // first, so a reversion on the completing edge still cancels the update.
    always_comb begin
        w_db_nxt  = sw_db;
        w_chg_nxt = '0;
        for (int i = 0; i < int'(N_SW); i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (r_s2[i] == sw_db[i]) begin
                w_cnt_nxt[i] = '0;
            end else if (r_cnt[i] == CNT_MAX) begin
                w_db_nxt[i]  = r_s2[i];
                w_cnt_nxt[i] = '0;
                w_chg_nxt[i] = 1'b1;
            end else begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= '0;
            r_s2    <= '0;
            sw_db   <= '0;
            sw_chg  <= '0;
            any_chg <= 1'b0;
            for (int i = 0; i < int'(N_SW); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1    <= sw_pin;
            r_s2    <= r_s1;
            sw_db   <= w_db_nxt;
            sw_chg  <= w_chg_nxt;
            any_chg <= |w_chg_nxt;
            for (int i = 0; i < int'(N_SW); i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

`ifdef SW_DEBOUNCE_EDGE_DIR_EN
    // The direction is the newly accepted level of each toggling bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_rise <= '0;
            sw_fall <= '0;
        end else begin
            sw_rise <= w_chg_nxt & w_db_nxt;
            sw_fall <= w_chg_nxt & ~w_db_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_debounce
// Purpose  : Self-checking bench for sw_debounce with STABLE_CYCLES = 4.
//            Directed steps drive sw_pin and queue the expected sw_db/sw_chg
//            event for the cycle it should appear. A monitor compares each
//            queued event on its cycle and checks all other cycles for quiet
//            outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_debounce;

    localparam int unsigned N_SW = 8;
    localparam int unsigned STAB = 4;
    // Drive at a falling edge that has count c; the next rising edge is k=c+1,
    // and the update edge is k+1+STAB. It is observed at the falling edge of
    // count c+2+STAB.
    localparam int LAT = STAB + 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_SW-1:0] sw_pin;
    logic [N_SW-1:0] sw_db;
    logic [N_SW-1:0] sw_chg;
    logic            any_chg;
`ifdef SW_DEBOUNCE_EDGE_DIR_EN
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;
`endif

    sw_debounce #(
        .N_SW          (N_SW),
        .STABLE_CYCLES (STAB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_pin  (sw_pin),
        .sw_db   (sw_db),
        .sw_chg  (sw_chg),
`ifdef SW_DEBOUNCE_EDGE_DIR_EN
        .sw_rise (sw_rise),
        .sw_fall (sw_fall),
`endif
        .any_chg (any_chg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] db;
        logic [7:0] chg;
    } exp_t;

    exp_t       q[$];
    logic [7:0] cur_db = 8'h00;
    int         total  = 0;
    int         bad    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_at(input int d, input logic [7:0] db, input logic [7:0] chg);
        exp_t e;
        e.cyc = cyc + d;
        e.db  = db;
        e.chg = chg;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("db_evt",  sw_db,   e.db);
            chk("chg_evt", sw_chg,  e.chg);
            chk("any_evt", any_chg, |e.chg);
`ifdef SW_DEBOUNCE_EDGE_DIR_EN
            chk("rise_evt", sw_rise, e.chg & e.db);
            chk("fall_evt", sw_fall, e.chg & ~e.db);
`endif
            cur_db = e.db;
        end else begin
            chk("db_idle",  sw_db,   cur_db);
            chk("chg_idle", sw_chg,  8'h00);
            chk("any_idle", any_chg, 1'b0);
`ifdef SW_DEBOUNCE_EDGE_DIR_EN
            chk("rise_idle", sw_rise, 8'h00);
            chk("fall_idle", sw_fall, 8'h00);
`endif
        end
    end

    initial begin
        rst    = 1'b1;
        sw_pin = 8'h00;
        step(3);
        chk("rst_db",  sw_db,   8'h00);
        chk("rst_chg", sw_chg,  8'h00);
        chk("rst_any", any_chg, 1'b0);

        // Quiet inputs after reset: nothing may change.
        rst = 1'b0;
        step(20);

        // A 3-cycle glitch on bit 1 is rejected.
        sw_pin = 8'h02;
        step(3);
        sw_pin = 8'h00;
        step(12);

        // A 6-cycle pulse on bit 1 is accepted, then its fall is accepted.
        sw_pin = 8'h02;
        expect_at(LAT, 8'h02, 8'h02);
        step(6);
        sw_pin = 8'h00;
        expect_at(LAT, 8'h00, 8'h02);
        step(12);

        // Two bits change together.
        sw_pin = 8'h05;
        expect_at(LAT, 8'h05, 8'h05);
        step(12);

        // Bit 3 chatters every 2 cycles, then settles high.
        for (int i = 0; i < 20; i++) begin
            sw_pin = (i % 2 == 0) ? 8'h0D : 8'h05;
            step(2);
        end
        sw_pin = 8'h0D;
        expect_at(LAT, 8'h0D, 8'h08);
        step(12);

        // Mixed rise and fall on the same edge.
        sw_pin = 8'h0F;
        expect_at(LAT, 8'h0F, 8'h02);
        step(12);
        sw_pin = 8'hF0;
        expect_at(LAT, 8'hF0, 8'hFF);
        step(12);

        // Asynchronous reset mid-count, between clock edges.
        sw_pin = 8'hFF;
        step(3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        q.delete();
        cur_db = 8'h00;
        #1;
        chk("arst_db",  sw_db,   8'h00);
        chk("arst_chg", sw_chg,  8'h00);
        chk("arst_any", any_chg, 1'b0);
        step(2);
        rst = 1'b0;
        expect_at(LAT, 8'hFF, 8'hFF);
        step(12);

        // Every queued event must have been consumed.
        for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
        chk("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
